// File: rtl/key_debounce_if.sv
// Key debounce port bundle: raw active-low pins in, debounced level and event pulses out.
// Master drives pins and consumes events; slave is the debouncer.
interface key_debounce_if #(
  parameter int KEY_NUM = 3
);
  logic [KEY_NUM-1:0] key_n;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser + debounce FSM producing clean level and press/release/long pulses.
// Latency: edge accepted DB_CYCLES+3 edges after the pin is first sampled in its new state.
// Backpressure: none; events are single-cycle pulses the consumer must catch.
module key_debounce #(
  parameter int KEY_NUM     = 3,
  parameter int DB_CYCLES   = 400000,
  parameter int LONG_CYCLES = 20000000
) (
  input  logic          sysclk,
  input  logic          rst_n,
  key_debounce_if.slave kif
);

  localparam int CW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic [1:0]    sync_ff;
    logic          sync;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          long_done;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    // sync is 1 while the key is released (pins are active-low)
    assign sync = sync_ff[1];

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        sync_ff   <= 2'b11;
        state     <= IDLE;
        cnt       <= '0;
        long_done <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync_ff   <= {sync_ff[0], kif.key_n[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state)
          IDLE: begin
            if (!sync) begin
              state <= PRESS_DB;
              cnt   <= '0;
            end
          end
          PRESS_DB: begin
            if (sync) begin
              state <= IDLE;
            end else if (cnt == DB_LAST) begin
              state     <= HELD;
              cnt       <= '0;
              long_done <= 1'b0;
              press_q   <= 1'b1;
              level_q   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            // release wins over the long-press check in the same cycle
            if (sync) begin
              state <= RELEASE_DB;
              cnt   <= '0;
            end else begin
              if (cnt == LONG_LAST && !long_done) begin
                long_q    <= 1'b1;
                long_done <= 1'b1;
              end
              if (cnt != '1) begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RELEASE_DB: begin
            // bounce back keeps long_done so one press never yields two long events
            if (!sync) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              release_q <= 1'b1;
              level_q   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign kif.key_level[i]   = level_q;
    assign kif.key_press[i]   = press_q;
    assign kif.key_release[i] = release_q;
    assign kif.key_long[i]    = long_q;

    a_evt_excl: assert property (@(posedge sysclk) disable iff (!rst_n)
      $onehot0({press_q, release_q, long_q}));
  end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;
  localparam int KN = 3;
  localparam int DB = 8;
  localparam int LG = 32;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  key_debounce_if #(.KEY_NUM(KN)) kif ();

  key_debounce #(
    .KEY_NUM    (KN),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LG)
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  always #25 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key changes debounced state after its synchronised value
  // has disagreed with the current level for DB+1 consecutive clock cycles.
  bit          m_s1[KN];
  bit          m_s2[KN];
  bit          m_lvl[KN];
  int          m_run[KN];
  int          m_lrun[KN];
  bit          m_ldone[KN];
  logic [KN-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0;

  always @(posedge sysclk) begin
    if (!rst_n) begin
      for (int i = 0; i < KN; i++) begin
        m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
        m_run[i] = 0; m_lrun[i] = 0; m_ldone[i] = 1'b0;
      end
      e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0;
    end else begin
      for (int i = 0; i < KN; i++) begin
        bit pr;
        pr = !m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = kif.key_n[i];
        e_prs[i] = 1'b0; e_rel[i] = 1'b0; e_lng[i] = 1'b0;
        if (pr != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i] = pr;
            m_run[i] = 0;
            if (pr) begin
              e_prs[i] = 1'b1; m_lrun[i] = 0; m_ldone[i] = 1'b0;
            end else begin
              e_rel[i] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[i]) begin
            if (m_run[i] > 0) begin
              m_lrun[i] = 0;
            end else begin
              if (m_lrun[i] == LG - 1 && !m_ldone[i]) begin
                e_lng[i] = 1'b1; m_ldone[i] = 1'b1;
              end
              if (m_lrun[i] < LG - 1) m_lrun[i]++;
            end
          end
          m_run[i] = 0;
        end
        e_lvl[i] = m_lvl[i];
      end
    end
  end

  logic [KN-1:0] kn = '1;
  logic [KN-1:0] s_lvl, s_prs, s_rel, s_lng;
  int c_prs[KN], c_rel[KN], c_lng[KN], lp_cyc[KN];
  int cyc = 0;

  task automatic clr_counts();
    for (int i = 0; i < KN; i++) begin
      c_prs[i] = 0; c_rel[i] = 0; c_lng[i] = 0; lp_cyc[i] = -1;
    end
  endtask

  task automatic set_keys(input logic [KN-1:0] v);
    kn = v;
    kif.key_n = v;
  endtask

  task automatic step();
    @(negedge sysclk);
    cyc++;
    s_lvl = kif.key_level; s_prs = kif.key_press;
    s_rel = kif.key_release; s_lng = kif.key_long;
    chk("level",   32'(s_lvl), 32'(e_lvl));
    chk("press",   32'(s_prs), 32'(e_prs));
    chk("release", 32'(s_rel), 32'(e_rel));
    chk("long",    32'(s_lng), 32'(e_lng));
    chk("excl", 32'((s_prs & s_rel) | (s_prs & s_lng) | (s_rel & s_lng)), 32'd0);
    for (int i = 0; i < KN; i++) begin
      c_prs[i] += int'(s_prs[i]);
      c_rel[i] += int'(s_rel[i]);
      c_lng[i] += int'(s_lng[i]);
      if (s_prs[i]) lp_cyc[i] = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int first;
    int rem[KN];
    clr_counts();
    set_keys(3'b000);
    rst_n = 1'b0;

    // 1: reset with all keys pressed, then re-detect after release
    run(5);
    rst_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (first == 0 && s_prs == 3'b111) first = e;
    end
    chk("t1_press_edge", 32'(first), 32'd11);
    chk("t1_level", 32'(s_lvl), 32'd7);
    set_keys(3'b111);
    run(15);

    // 2: clean press of key0 with long press, then release latency
    clr_counts();
    set_keys(3'b110);
    first = 0;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (first == 0 && s_prs[0]) first = e;
    end
    chk("t2_press_edge", 32'(first), 32'd11);
    chk("t2_press_cnt", 32'(c_prs[0]), 32'd1);
    chk("t2_long_cnt", 32'(c_lng[0]), 32'd1);
    chk("t2_level", 32'(s_lvl[0]), 32'd1);
    set_keys(3'b111);
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (first == 0 && s_rel[0]) first = e;
    end
    chk("t2_rel_edge", 32'(first), 32'd11);
    chk("t2_rel_level", 32'(s_lvl[0]), 32'd0);

    // 3: press bounce on key1 never accepted
    clr_counts();
    first = 0;
    for (int r = 0; r < 4; r++) begin
      set_keys(3'b101); run(5);
      if (s_lvl[1]) first = 1;
      set_keys(3'b111); run(2);
      if (s_lvl[1]) first = 1;
    end
    run(20);
    chk("t3_events", 32'(c_prs[1] + c_rel[1] + c_lng[1]), 32'd0);
    chk("t3_level_seen", 32'(first), 32'd0);

    // 4: release bounce on key2 after a long press
    clr_counts();
    set_keys(3'b011); run(50);
    chk("t4_long_first", 32'(c_lng[2]), 32'd1);
    set_keys(3'b111); run(3);
    set_keys(3'b011); run(3);
    set_keys(3'b111); run(20);
    chk("t4_long_total", 32'(c_lng[2]), 32'd1);
    chk("t4_rel_cnt", 32'(c_rel[2]), 32'd1);
    chk("t4_level", 32'(s_lvl[2]), 32'd0);

    // 5: reset in the middle of key0 press debounce while key2 is held
    clr_counts();
    set_keys(3'b011); run(15);
    set_keys(3'b010); run(7);
    chk("t5_no_early_press", 32'(c_prs[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", 32'(kif.key_level | kif.key_press | kif.key_release | kif.key_long), 32'd0);
    run(2);
    rst_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (first == 0 && s_prs[0]) first = e;
    end
    chk("t5_press_edge", 32'(first), 32'd11);
    set_keys(3'b111); run(15);

    // 6: staggered concurrent presses on key0 and key1
    clr_counts();
    set_keys(3'b110); run(2);
    set_keys(3'b100); run(20);
    chk("t6_both_pressed", 32'(c_prs[0] + c_prs[1]), 32'd2);
    chk("t6_gap", 32'(lp_cyc[1] - lp_cyc[0]), 32'd2);
    set_keys(3'b111); run(15);

    // random bouncing and holds on all keys, one reset in the middle
    for (int i = 0; i < KN; i++) rem[i] = $urandom_range(1, 12);
    for (int c = 0; c < 2500; c++) begin
      logic [KN-1:0] v;
      v = kn;
      for (int i = 0; i < KN; i++) begin
        if (rem[i] == 0) begin
          v[i] = ~v[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(35, 50) : $urandom_range(1, 12);
        end
        rem[i]--;
      end
      set_keys(v);
      if (c == 1200) rst_n = 1'b0;
      if (c == 1203) rst_n = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
